reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Decode-stage register file for the 16-bit pipeline.
- Holds eight general registers R0–R7 and four special registers: SP, IH, T, RA.
- Drives the two operand values and the T flag sampled by the ID/EX pipeline register at the next CLK edge.
- Written once per cycle from the write-back stage; includes same-cycle write-to-read bypass so the 3-stage gap from write-back needs no extra stall.

Parameters:
- SP_RESET, 16'hBF00, value loaded into SP at reset.
- IH_RESET, 16'h0000, value loaded into IH at reset.

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  synchronous active-high reset
- rxAddr  in  3  GPR index for read port 1
- ryAddr  in  3  GPR index for read port 2
- readSpecReg  in  2  port-1 source: 00 GPR[rxAddr], 01 SP, 10 IH, 11 RA
- wbRegWrite  in  1  write enable, GPR
- wbRegAddr  in  3  GPR write index
- wbSpecWrite  in  2  special write select: 00 none, 01 SP, 10 IH, 11 T
- wbRaWrite  in  1  write enable, RA
- wbData  in  16  write data, shared by all write targets
- outData1  out  16  port-1 read value
- outData2  out  16  port-2 read value, always GPR[ryAddr]
- outT  out  1  T != 0, for BTEQZ/BTNEZ resolution
- dbgSel  in  4  debug select: 0–7 GPR, 8 SP, 9 IH, 10 T, 11 RA, others 0
- dbgData  out  16  debug read value, no bypass

Behaviour:
- Reset:
  - On a posedge with RST=1: R0–R7, T and RA become 0; SP becomes SP_RESET; IH becomes IH_RESET.
  - All writes are ignored on that edge.
- Write rules:
  - Writes take effect at posedge when RST=0. Write latency is 1 edge; the bypass makes read latency effectively 0.
  - All enabled targets are written in the same edge with wbData. GPR, one special register and RA may be written simultaneously, with no priority conflict.
  - R0 is an ordinary register, not hardwired to zero.
- Reads:
  - Reads are combinational from addresses and state.
  - Bypass: if RST=0 and a write enabled this cycle targets the register selected by a read port, that port outputs wbData instead of stored state. Applies to:
    - port 1 GPR, SP, IH and RA selections;
    - port 2 GPR selection;
    - outT (T written this cycle: outT = |wbData).
  - Bypass is disabled while RST=1; outputs then show stored state.
  - After the reset edge with no writes pending: outData1 = outData2 = 0 for GPR selects; SP select = SP_RESET; outT = 0; dbgData = 0 except SP/IH selects.
- Address matching: bypass on port 1 compares rxAddr only when readSpecReg=00. When readSpecReg≠00, a GPR write never bypasses port 1.
- dbgData:
  - Always stored state, no bypass, so the display shows committed values only.
  - dbgSel 12–15 return 16'h0000.
- No internal stall; upstream hazard logic holds inputs stable if needed. State is only modified by write enables, so holding is safe.
- Width: all data 16 bits. No arithmetic inside; T stores the full 16-bit wbData, and outT is its reduction-OR.

Decomposition:
- Shared package:
  - readSpecReg encodings: SPEC_RD_GPR, SPEC_RD_SP, SPEC_RD_IH, SPEC_RD_RA.
  - wbSpecWrite encodings: SPEC_WR_NONE, SPEC_WR_SP, SPEC_WR_IH, SPEC_WR_T.
  - dbgSel codes.
  - Default reset constants.
- One natural sub-module: reg_bypass_mux.
  - Function: given the stored value, a match flag and wbData, selects the output.
  - Instanced for port 1, port 2 and T.
- Storage, write decode and debug mux stay in reg_file.

Test Plan:
- Reset:
  - Stimulus: RST=1 for one edge with wbRegWrite=1, wbRegAddr=3, wbData=16'h1234.
  - Response: after the edge, dbgSel=3 gives 0000, dbgSel=8 gives BF00, outT=0.
- GPR write then read:
  - Stimulus: write R5=16'hA5A5, next cycle rxAddr=5, readSpecReg=00.
  - Response: outData1=A5A5; outData2 with ryAddr=5 also A5A5.
- Same-cycle bypass:
  - Stimulus: wbRegWrite=1, wbRegAddr=2, wbData=16'h0F0F, rxAddr=2, ryAddr=2.
  - Response: both outputs 0F0F before the edge; dbgSel=2 still shows the old value until the edge.
- Special registers:
  - Stimulus: wbSpecWrite=01 with 16'h7000 and wbRaWrite=1 in the same cycle.
  - Response: next cycle readSpecReg=01 gives 7000 and readSpecReg=11 gives 7000. Then write T=16'h0000: outT=0 in that cycle via bypass; write T=16'h0080: outT=1.
- No false bypass:
  - Stimulus: readSpecReg=10 (IH=0), rxAddr=4, GPR write R4=16'hFFFF.
  - Response: outData1 stays 0000.
- Reset mid-operation:
  - Stimulus: RST=1 with wbSpecWrite=01, wbData=16'h1111.
  - Response: outData1 (select SP) shows stored SP, not 1111, during reset; after the edge SP=BF00.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared encodings and reset constants for the decode-stage register file.
// Imported by reg_file and reg_bypass_mux.
package reg_file_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int NUM_GPR = 8;

    typedef enum logic [1:0] {
        SPEC_RD_GPR = 2'b00,
        SPEC_RD_SP  = 2'b01,
        SPEC_RD_IH  = 2'b10,
        SPEC_RD_RA  = 2'b11
    } spec_rd_e;

    typedef enum logic [1:0] {
        SPEC_WR_NONE = 2'b00,
        SPEC_WR_SP   = 2'b01,
        SPEC_WR_IH   = 2'b10,
        SPEC_WR_T    = 2'b11
    } spec_wr_e;

    // dbgSel codes above the GPR range; 12-15 read as zero
    localparam logic [3:0] DBG_SP = 4'd8;
    localparam logic [3:0] DBG_IH = 4'd9;
    localparam logic [3:0] DBG_T  = 4'd10;
    localparam logic [3:0] DBG_RA = 4'd11;

    localparam logic [DATA_W-1:0] SP_RESET_DEFAULT = 16'hBF00;
    localparam logic [DATA_W-1:0] IH_RESET_DEFAULT = 16'h0000;

endpackage

// File: rtl/reg_bypass_mux.sv
// Selects the write-back value over stored state when this cycle's write
// targets the register being read.
module reg_bypass_mux
    import reg_file_pkg::*;
(
    input  logic [DATA_W-1:0] stored_val,
    input  logic              match,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] out_val
);

    assign out_val = match ? wb_data : stored_val;

endmodule

// File: rtl/reg_file.sv
// Decode-stage register file: R0-R7 plus SP, IH, T, RA, with same-cycle
// write-to-read bypass on both operand ports and the T flag.
module reg_file
    import reg_file_pkg::*;
#(
    parameter logic [15:0] SP_RESET = SP_RESET_DEFAULT,
    parameter logic [15:0] IH_RESET = IH_RESET_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  rxAddr,
    input  logic [2:0]  ryAddr,
    input  logic [1:0]  readSpecReg,
    input  logic        wbRegWrite,
    input  logic [2:0]  wbRegAddr,
    input  logic [1:0]  wbSpecWrite,
    input  logic        wbRaWrite,
    input  logic [15:0] wbData,
    output logic [15:0] outData1,
    output logic [15:0] outData2,
    output logic        outT,
    input  logic [3:0]  dbgSel,
    output logic [15:0] dbgData
);

    logic [DATA_W-1:0] gpr_q [NUM_GPR];
    logic [DATA_W-1:0] gpr_d [NUM_GPR];
    logic [DATA_W-1:0] sp_q, sp_d;
    logic [DATA_W-1:0] ih_q, ih_d;
    logic [DATA_W-1:0] t_q, t_d;
    logic [DATA_W-1:0] ra_q, ra_d;

    logic [DATA_W-1:0] rd1_stored;
    logic              rd1_match;
    logic              rd2_match;
    logic              t_match;
    logic [DATA_W-1:0] t_rd;

    // Every enabled target takes wbData on the same edge; targets are disjoint
    always_comb begin
        gpr_d = gpr_q;
        sp_d  = sp_q;
        ih_d  = ih_q;
        t_d   = t_q;
        ra_d  = ra_q;
        if (wbRegWrite) begin
            gpr_d[wbRegAddr] = wbData;
        end
        case (spec_wr_e'(wbSpecWrite))
            SPEC_WR_SP: sp_d = wbData;
            SPEC_WR_IH: ih_d = wbData;
            SPEC_WR_T:  t_d  = wbData;
            default:    ;
        endcase
        if (wbRaWrite) begin
            ra_d = wbData;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= '0;
            end
            sp_q <= SP_RESET;
            ih_q <= IH_RESET;
            t_q  <= '0;
            ra_q <= '0;
        end else begin
            gpr_q <= gpr_d;
            sp_q  <= sp_d;
            ih_q  <= ih_d;
            t_q   <= t_d;
            ra_q  <= ra_d;
        end
    end

    // A GPR write may only bypass port 1 when port 1 is reading a GPR
    always_comb begin
        rd1_stored = '0;
        rd1_match  = 1'b0;
        case (spec_rd_e'(readSpecReg))
            SPEC_RD_GPR: begin
                rd1_stored = gpr_q[rxAddr];
                rd1_match  = wbRegWrite && (wbRegAddr == rxAddr);
            end
            SPEC_RD_SP: begin
                rd1_stored = sp_q;
                rd1_match  = (wbSpecWrite == SPEC_WR_SP);
            end
            SPEC_RD_IH: begin
                rd1_stored = ih_q;
                rd1_match  = (wbSpecWrite == SPEC_WR_IH);
            end
            SPEC_RD_RA: begin
                rd1_stored = ra_q;
                rd1_match  = wbRaWrite;
            end
            default: ;
        endcase
        rd1_match = rd1_match && !RST;
    end

    assign rd2_match = !RST && wbRegWrite && (wbRegAddr == ryAddr);
    assign t_match   = !RST && (wbSpecWrite == SPEC_WR_T);

    reg_bypass_mux u_port1_mux (
        .stored_val (rd1_stored),
        .match      (rd1_match),
        .wb_data    (wbData),
        .out_val    (outData1)
    );

    reg_bypass_mux u_port2_mux (
        .stored_val (gpr_q[ryAddr]),
        .match      (rd2_match),
        .wb_data    (wbData),
        .out_val    (outData2)
    );

    reg_bypass_mux u_t_mux (
        .stored_val (t_q),
        .match      (t_match),
        .wb_data    (wbData),
        .out_val    (t_rd)
    );

    assign outT = |t_rd;

    // Debug view shows committed state only, never the bypassed value
    always_comb begin
        dbgData = '0;
        if (!dbgSel[3]) begin
            dbgData = gpr_q[dbgSel[2:0]];
        end else begin
            case (dbgSel)
                DBG_SP:  dbgData = sp_q;
                DBG_IH:  dbgData = ih_q;
                DBG_T:   dbgData = t_q;
                DBG_RA:  dbgData = ra_q;
                default: dbgData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: expectations are queued as stimulus is
// applied and drained against the combinational outputs before each edge.
module tb_reg_file;

    logic        CLK;
    logic        RST;
    logic [2:0]  rxAddr;
    logic [2:0]  ryAddr;
    logic [1:0]  readSpecReg;
    logic        wbRegWrite;
    logic [2:0]  wbRegAddr;
    logic [1:0]  wbSpecWrite;
    logic        wbRaWrite;
    logic [15:0] wbData;
    logic [15:0] outData1;
    logic [15:0] outData2;
    logic        outT;
    logic [3:0]  dbgSel;
    logic [15:0] dbgData;

    typedef enum int { SRC_OUT1, SRC_OUT2, SRC_OUTT, SRC_DBG } src_e;

    typedef struct {
        string       tag;
        src_e        src;
        logic [3:0]  dbg;
        logic [15:0] exp;
    } sb_entry_t;

    sb_entry_t sbQueue[$];
    int compareCount = 0;
    int failCount = 0;

    reg_file dut (
        .CLK         (CLK),
        .RST         (RST),
        .rxAddr      (rxAddr),
        .ryAddr      (ryAddr),
        .readSpecReg (readSpecReg),
        .wbRegWrite  (wbRegWrite),
        .wbRegAddr   (wbRegAddr),
        .wbSpecWrite (wbSpecWrite),
        .wbRaWrite   (wbRaWrite),
        .wbData      (wbData),
        .outData1    (outData1),
        .outData2    (outData2),
        .outT        (outT),
        .dbgSel      (dbgSel),
        .dbgData     (dbgData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compareCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic regWr, input logic [2:0] regAddr,
                                 input logic [1:0] specWr, input logic raWr, input logic [15:0] data);
        RST         = rst;
        wbRegWrite  = regWr;
        wbRegAddr   = regAddr;
        wbSpecWrite = specWr;
        wbRaWrite   = raWr;
        wbData      = data;
    endtask

    task automatic setRead(input logic [2:0] rx, input logic [2:0] ry, input logic [1:0] spec);
        rxAddr      = rx;
        ryAddr      = ry;
        readSpecReg = spec;
    endtask

    task automatic expectOut(input string tag, input src_e src, input logic [3:0] dbg, input logic [15:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.src = src;
        e.dbg = dbg;
        e.exp = exp;
        sbQueue.push_back(e);
    endtask

    // Pops every queued expectation and compares it with the settled output
    task automatic drainScoreboard();
        sb_entry_t e;
        logic [15:0] obs;
        while (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            if (e.src == SRC_DBG) dbgSel = e.dbg;
            #1;
            case (e.src)
                SRC_OUT1: obs = outData1;
                SRC_OUT2: obs = outData2;
                SRC_OUTT: obs = {15'b0, outT};
                default:  obs = dbgData;
            endcase
            checkOutput(e.tag, obs, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        dbgSel = 4'd0;
        setRead(3'd0, 3'd0, 2'b00);
        applyStimulus(1'b1, 1'b1, 3'd3, 2'b00, 1'b0, 16'h1234);
        tick();

        // Reset state; the R3 write during reset must be dropped
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b00, 1'b0, 16'h0000);
        setRead(3'd0, 3'd0, 2'b00);
        expectOut("rst_dbg_r3", SRC_DBG, 4'd3, 16'h0000);
        expectOut("rst_dbg_sp", SRC_DBG, 4'd8, 16'hBF00);
        expectOut("rst_dbg_ih", SRC_DBG, 4'd9, 16'h0000);
        expectOut("rst_dbg_ra", SRC_DBG, 4'd11, 16'h0000);
        expectOut("rst_outT", SRC_OUTT, 4'd0, 16'h0000);
        expectOut("rst_out1_gpr", SRC_OUT1, 4'd0, 16'h0000);
        expectOut("rst_out2_gpr", SRC_OUT2, 4'd0, 16'h0000);
        drainScoreboard();
        setRead(3'd0, 3'd0, 2'b01);
        expectOut("rst_out1_sp", SRC_OUT1, 4'd0, 16'hBF00);
        drainScoreboard();

        // GPR write then read, and R0 is writable
        applyStimulus(1'b0, 1'b1, 3'd5, 2'b00, 1'b0, 16'hA5A5);
        tick();
        applyStimulus(1'b0, 1'b1, 3'd0, 2'b00, 1'b0, 16'h00FF);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b00, 1'b0, 16'h0000);
        setRead(3'd5, 3'd5, 2'b00);
        expectOut("gpr_out1_r5", SRC_OUT1, 4'd0, 16'hA5A5);
        expectOut("gpr_out2_r5", SRC_OUT2, 4'd0, 16'hA5A5);
        expectOut("gpr_dbg_r0", SRC_DBG, 4'd0, 16'h00FF);
        drainScoreboard();

        // Same-cycle bypass on both ports, debug still shows committed value
        applyStimulus(1'b0, 1'b1, 3'd2, 2'b00, 1'b0, 16'h0F0F);
        setRead(3'd2, 3'd2, 2'b00);
        expectOut("byp_out1", SRC_OUT1, 4'd0, 16'h0F0F);
        expectOut("byp_out2", SRC_OUT2, 4'd0, 16'h0F0F);
        expectOut("byp_dbg_old", SRC_DBG, 4'd2, 16'h0000);
        drainScoreboard();
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b00, 1'b0, 16'h0000);
        expectOut("byp_dbg_new", SRC_DBG, 4'd2, 16'h0F0F);
        drainScoreboard();

        // SP and RA written together
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b01, 1'b1, 16'h7000);
        setRead(3'd0, 3'd0, 2'b01);
        expectOut("spec_byp_sp", SRC_OUT1, 4'd0, 16'h7000);
        drainScoreboard();
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b00, 1'b0, 16'h0000);
        setRead(3'd0, 3'd0, 2'b01);
        expectOut("spec_out1_sp", SRC_OUT1, 4'd0, 16'h7000);
        expectOut("spec_dbg_sp", SRC_DBG, 4'd8, 16'h7000);
        drainScoreboard();
        setRead(3'd0, 3'd0, 2'b11);
        expectOut("spec_out1_ra", SRC_OUT1, 4'd0, 16'h7000);
        expectOut("spec_dbg_ra", SRC_DBG, 4'd11, 16'h7000);
        drainScoreboard();

        // T flag via bypass, then committed
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b11, 1'b0, 16'h0000);
        expectOut("t_zero_byp", SRC_OUTT, 4'd0, 16'h0000);
        drainScoreboard();
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b11, 1'b0, 16'h0080);
        expectOut("t_set_byp", SRC_OUTT, 4'd0, 16'h0001);
        expectOut("t_dbg_before", SRC_DBG, 4'd10, 16'h0000);
        drainScoreboard();
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b00, 1'b0, 16'h0000);
        expectOut("t_set_stored", SRC_OUTT, 4'd0, 16'h0001);
        expectOut("t_dbg_after", SRC_DBG, 4'd10, 16'h0080);
        drainScoreboard();

        // GPR write must not bypass port 1 when it reads IH
        applyStimulus(1'b0, 1'b1, 3'd4, 2'b00, 1'b0, 16'hFFFF);
        setRead(3'd4, 3'd4, 2'b10);
        expectOut("nofalse_out1_ih", SRC_OUT1, 4'd0, 16'h0000);
        expectOut("nofalse_out2_r4", SRC_OUT2, 4'd0, 16'hFFFF);
        drainScoreboard();
        tick();

        // GPR, IH and RA in one edge; port 2 on another address is unaffected
        applyStimulus(1'b0, 1'b1, 3'd6, 2'b10, 1'b1, 16'h3C3C);
        setRead(3'd0, 3'd7, 2'b10);
        expectOut("multi_byp_ih", SRC_OUT1, 4'd0, 16'h3C3C);
        expectOut("multi_out2_r7", SRC_OUT2, 4'd0, 16'h0000);
        drainScoreboard();
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b00, 1'b0, 16'h0000);
        expectOut("multi_dbg_r6", SRC_DBG, 4'd6, 16'h3C3C);
        expectOut("multi_dbg_ih", SRC_DBG, 4'd9, 16'h3C3C);
        expectOut("multi_dbg_ra", SRC_DBG, 4'd11, 16'h3C3C);
        expectOut("multi_dbg_r4", SRC_DBG, 4'd4, 16'hFFFF);
        expectOut("dbg_unused_12", SRC_DBG, 4'd12, 16'h0000);
        expectOut("dbg_unused_15", SRC_DBG, 4'd15, 16'h0000);
        drainScoreboard();

        // Reset mid-operation: no bypass while RST is high
        applyStimulus(1'b1, 1'b1, 3'd5, 2'b01, 1'b0, 16'h1111);
        setRead(3'd0, 3'd5, 2'b01);
        expectOut("midrst_out1_sp", SRC_OUT1, 4'd0, 16'h7000);
        expectOut("midrst_out2_r5", SRC_OUT2, 4'd0, 16'hA5A5);
        drainScoreboard();
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0, 2'b00, 1'b0, 16'h0000);
        expectOut("midrst_sp_after", SRC_OUT1, 4'd0, 16'hBF00);
        expectOut("midrst_out2_after", SRC_OUT2, 4'd0, 16'h0000);
        expectOut("midrst_outT", SRC_OUTT, 4'd0, 16'h0000);
        expectOut("midrst_dbg_ih", SRC_DBG, 4'd9, 16'h0000);
        expectOut("midrst_dbg_t", SRC_DBG, 4'd10, 16'h0000);
        drainScoreboard();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
